// File: rtl/booth_multiplier_if.sv
// Start/ready handshake and product bus between the control unit and the Booth multiplier.
// The master drives operands and start; the slave returns hi/lo with ready/busy status.
interface booth_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             ready;
  logic             busy;

  modport master (output start, a, b, input hi, lo, ready, busy);
  modport slave  (input start, a, b, output hi, lo, ready, busy);
endinterface

// File: rtl/booth_multiplier.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier, one iteration per clock.
// The product lands in hi/lo with a one-cycle ready pulse WIDTH edges after accept.
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  booth_multiplier_if.slave   bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH:0]   m_q, m_d;
  logic signed [WIDTH:0]   acc_q, acc_d;
  logic        [WIDTH-1:0] q_q, q_d;
  logic                    q1_q, q1_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic        [WIDTH-1:0] hi_q, hi_d;
  logic        [WIDTH-1:0] lo_q, lo_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  logic signed [WIDTH:0]   acc_step;
  logic signed [WIDTH:0]   acc_sh;
  logic        [WIDTH-1:0] q_sh;

  // WIDTH+1-bit accumulator keeps A-M exact even when M is the most negative operand.
  function automatic logic signed [WIDTH:0] booth_op(
    input logic [1:0]            sel,
    input logic signed [WIDTH:0] acc,
    input logic signed [WIDTH:0] m
  );
    case (sel)
      2'b01:   return acc + m;
      2'b10:   return acc - m;
      default: return acc;
    endcase
  endfunction

  always_comb begin
    acc_step = booth_op({q_q[0], q1_q}, acc_q, m_q);
    acc_sh   = acc_step >>> 1;
    q_sh     = {acc_step[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = $signed({bus.a[WIDTH-1], bus.a});
          acc_d   = '0;
          q_d     = bus.b;
          q1_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = acc_sh[WIDTH-1:0];
          lo_d    = q_sh;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed vector table, handshake corner
// sequences and random signed operands against a plain 64-bit multiply reference.
module tb_booth_multiplier;
  localparam int W = 32;

  logic clk;
  logic reset;
  booth_multiplier_if #(.WIDTH(W)) bus ();

  booth_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] cur_hi, cur_lo;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // Runs one operation from IDLE. restart_at>0 raises start (with new operands) at that
  // cycle and holds it through DONE; the DUT must ignore it.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                       input int restart_at, output logic [W-1:0] h, output logic [W-1:0] l);
    int k;
    int nbusy;
    int unstable;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    k = 0;
    nbusy = bus.busy ? 1 : 0;
    unstable = 0;
    while (!bus.ready && k < 100) begin
      if (bus.hi !== cur_hi || bus.lo !== cur_lo) unstable++;
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (restart_at > 0 && k == restart_at) begin
        bus.start = 1'b1;
        bus.a = 32'd100;
        bus.b = 32'd100;
      end
    end
    chk({tag, " latency"}, 64'(k), 64'd32);
    chk({tag, " busy_cycles"}, 64'(nbusy), 64'd32);
    chk({tag, " hold_while_run"}, 64'(unstable), 64'd0);
    h = bus.hi;
    l = bus.lo;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, " ready_width"}, {63'd0, bus.ready}, 64'd0);
    cur_hi = h;
    cur_lo = l;
  endtask

  initial begin
    logic [W-1:0] h, l, ra, rb;
    logic [63:0] p;
    int seen;
    logic [W-1:0] corner [5];

    tbl[0] = '{a: 32'd7,          b: 32'hFFFFFFFD, ehi: 32'hFFFFFFFF, elo: 32'hFFFFFFEB};
    tbl[1] = '{a: 32'h80000000,   b: 32'h80000000, ehi: 32'h40000000, elo: 32'h00000000};
    tbl[2] = '{a: 32'h80000000,   b: 32'hFFFFFFFF, ehi: 32'h00000000, elo: 32'h80000000};
    tbl[3] = '{a: 32'd0,          b: 32'h12345678, ehi: 32'h00000000, elo: 32'h00000000};
    tbl[4] = '{a: 32'h0000FFFF,   b: 32'h0000FFFF, ehi: 32'h00000000, elo: 32'hFFFE0001};
    tbl[5] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF, ehi: 32'h00000000, elo: 32'h00000001};
    corner[0] = 32'h0;
    corner[1] = 32'h1;
    corner[2] = 32'hFFFFFFFF;
    corner[3] = 32'h80000000;
    corner[4] = 32'h7FFFFFFF;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    cur_hi = '0;
    cur_lo = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, bus.hi}, 64'd0);
    chk("reset_lo", {32'd0, bus.lo}, 64'd0);
    chk("reset_ready_busy", {62'd0, bus.ready, bus.busy}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, $sformatf("vec%0d", i), 0, h, l);
      chk($sformatf("vec%0d_hi", i), {32'd0, h}, {32'd0, tbl[i].ehi});
      chk($sformatf("vec%0d_lo", i), {32'd0, l}, {32'd0, tbl[i].elo});
    end

    // start raised mid-run and held through DONE must be ignored
    do_op(32'd5, 32'd6, "ignore_start", 10, h, l);
    chk("ignore_start_prod", {h, l}, 64'd30);
    repeat (3) begin
      @(negedge clk);
      chk("ignore_start_busy", {63'd0, bus.busy}, 64'd0);
    end
    chk("ignore_start_hold", {bus.hi, bus.lo}, 64'd30);

    // reset in the middle of an operation discards it
    do_op(32'd3, 32'd4, "pre_reset", 0, h, l);
    chk("pre_reset_prod", {h, l}, 64'd12);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd9;
    bus.b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_run_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("async_reset_prod", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready || bus.busy) seen++;
    end
    chk("no_ready_after_reset", 64'(seen), 64'd0);
    chk("prod_after_reset", {bus.hi, bus.lo}, 64'd0);
    do_op(32'd2, 32'd2, "post_reset", 0, h, l);
    chk("post_reset_prod", {h, l}, 64'd4);

    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      p = ref_prod(ra, rb);
      do_op(ra, rb, "rand", 0, h, l);
      chk($sformatf("rand%0d a=%h b=%h", i, ra, rb), {h, l}, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential signed 32x32 multiplier for the hi/lo unit. It is the multiply-side counterpart of the divider and uses the same start/ready handshake.
- Implements radix-2 Booth recoding, one iteration per clock. The 64-bit product is written to hi (upper word) and lo (lower word) for mfhi/mflo.
- Driven by the control unit's `mult` state; `ready` tells control to advance.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits split across hi/lo.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, two's complement, captured on accept
- b  input  WIDTH  multiplier, two's complement, captured on accept
- hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
- lo  output  WIDTH  product bits [WIDTH-1:0]
- ready  output  1  one-cycle pulse: hi/lo hold the new product
- busy  output  1  high while iterations are in progress

Behaviour:
- Reset (async, any state): state=IDLE; hi=0, lo=0, ready=0, busy=0; internal registers and counter cleared. Any in-flight operation is discarded and hi/lo do not update.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → capture M=a sign-extended to WIDTH+1 bits; load A=0 (WIDTH+1 bits), Q=b, q_1=0, count=0.
  - Go to RUN with busy=1.
  - start=0 → remain in IDLE; outputs hold.
- RUN, one iteration per edge, with {Q[0],q_1} selecting the operation:
  - 01: A=A+M
  - 10: A=A−M
  - 00 and 11: A unchanged
  - After the add/sub, arithmetic shift right of {A,Q,q_1} by 1, replicating A's MSB. Then count=count+1.
- The WIDTH+1-bit accumulator prevents overflow when M = −2^(WIDTH−1). All arithmetic is two's complement modulo 2^(WIDTH+1) in A.
- Final iteration (count==WIDTH−1), on the same edge:
  - Perform the step, then load hi=A[WIDTH−1:0] and lo=Q of the shifted result.
  - Set ready=1, busy=0; go to DONE.
- Latency: start accepted at edge E0; iterations occur at E1..E32; ready is high for exactly the one cycle following E32 (WIDTH edges after accept).
- DONE: next edge → ready=0, go to IDLE unconditionally. start asserted during DONE is ignored; the requester re-asserts it in IDLE.
- start in RUN or DONE is ignored. a/b changes after accept have no effect.
- hi/lo change only at completion. They hold the last product indefinitely, including across later idle cycles and while a new operation runs.
- The product is exact for all 2^(2·WIDTH) operand pairs, matching the signed full product ($signed(a)*$signed(b)) truncated to 2*WIDTH bits.
- No divide-by-zero analogue: a or b = 0 yields hi=0, lo=0 at normal latency (no early exit).

Test Plan:
- a=7, b=−3 (0xFFFFFFFD), start one cycle → ready exactly 32 cycles after the accept edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
- a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0x00000000. Also a=0x80000000, b=0xFFFFFFFF → hi=0x00000000, lo=0x80000000, checking accumulator overflow handling.
- a=0, b=0x12345678 → hi=0, lo=0 at normal latency. Then a=0x0000FFFF, b=0x0000FFFF → hi=0, lo=0xFFFE0001.
- Start 5×6; at cycle 10 raise start with a=100, b=100 and change a/b → result still hi=0, lo=30; second request not accepted; start held through DONE is not accepted either.
- Complete 3×4 (lo=12), then start 9×9 and assert reset at cycle 15 → hi=0, lo=0, ready never pulses, busy=0 immediately. After release, 2×2 → lo=4.
- Random 1000 signed pairs compared against the 64-bit reference product; hi/lo stable between ready pulses.
